dual_grant_rr_arbiter: RTL

- Round-robin arbiter that issues up to two one-hot grants per cycle to a pool of NUM_REQ requesters sharing a dual-ported resource.
- Grant 0 goes to the first active requester at or after the priority pointer, in circular order. Grant 1 goes to the second such requester.
- Grants are registered. The pointer advances past the last requester granted, which gives fairness.
- Sits in front of any two-slot shared resource (dual-issue unit, two-port memory) that is fed by the second-bit-set finding datapath.

---
 rtl/dual_grant_arb_pkg.sv | 50 +++++
 rtl/lsb_second_bit_set_finder.sv | 17 +
 rtl/dual_grant_rr_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/dual_grant_arb_pkg.sv
// Shared types and helpers for the dual-grant round-robin arbiter.
// Vectors are handled at the maximum supported width; callers pass the live width.
package dual_grant_arb_pkg;

  localparam int unsigned NumReqDefault = 12;
  localparam int unsigned MaxReq        = 32;

  typedef logic [$clog2(MaxReq)-1:0] ptr_t;
  typedef logic [MaxReq-1:0]         req_vec_t;

  // Circular right rotate of the low 'width' bits of v by sh (sh < width).
  function automatic req_vec_t rotr(input req_vec_t v, input ptr_t sh, input int unsigned width);
    req_vec_t    r;
    int unsigned src;
    r = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < width) begin
        src = i + 32'(sh);
        if (src >= width) src = src - width;
        r[5'(i)] = v[src[4:0]];
      end
    end
    return r;
  endfunction

  // Circular left rotate of the low 'width' bits of v by sh (sh < width).
  function automatic req_vec_t rotl(input req_vec_t v, input ptr_t sh, input int unsigned width);
    req_vec_t    r;
    int unsigned src;
    r = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < width) begin
        src = (i >= 32'(sh)) ? (i - 32'(sh)) : (i + width - 32'(sh));
        r[5'(i)] = v[src[4:0]];
      end
    end
    return r;
  endfunction

  // Index of the set bit of a one-hot vector; zero for an all-zero vector.
  function automatic ptr_t onehot_to_idx(input req_vec_t v);
    ptr_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (v[5'(i)]) idx = idx | ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lsb_second_bit_set_finder.sv
// Finds the second-lowest set bit of a vector and returns it one-hot (zero if fewer than two).
module lsb_second_bit_set_finder #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] rest;

  // Clear the lowest set bit, then isolate the lowest remaining one.
  always_comb begin
    rest  = in_i & (in_i - WIDTH'(1));
    out_o = rest & (~rest + WIDTH'(1));
  end

endmodule

// File: rtl/dual_grant_rr_arbiter.sv
// Round-robin arbiter issuing up to two registered one-hot grants per cycle.
// The priority pointer moves past the last requester granted.
module dual_grant_rr_arbiter
  import dual_grant_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDefault,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               hold_i,
  output logic [NUM_REQ-1:0] gnt0_o,
  output logic [NUM_REQ-1:0] gnt1_o,
  output logic [1:0]         gnt_cnt_o,
  output logic [PTR_W-1:0]   ptr_o
);

  logic [NUM_REQ-1:0] gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [1:0]         gnt_cnt_q, gnt_cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  req_vec_t           rot_ext, nxt0_ext, nxt1_ext, sel_ext;
  logic [NUM_REQ-1:0] rot, first, second, nxt0, nxt1;
  ptr_t               last_idx;
  logic               unused_ext;

  lsb_second_bit_set_finder #(
    .WIDTH (NUM_REQ)
  ) u_second (
    .in_i  (rot),
    .out_o (second)
  );

  // Rotate requests so the pointer sits at bit 0, pick the lowest one inline, rotate back.
  always_comb begin
    rot_ext  = rotr(req_vec_t'(req_i), ptr_t'(ptr_q), NUM_REQ);
    rot      = rot_ext[NUM_REQ-1:0];
    first    = rot & (~rot + NUM_REQ'(1));
    nxt0_ext = rotl(req_vec_t'(first), ptr_t'(ptr_q), NUM_REQ);
    nxt1_ext = rotl(req_vec_t'(second), ptr_t'(ptr_q), NUM_REQ);
    nxt0     = nxt0_ext[NUM_REQ-1:0];
    nxt1     = nxt1_ext[NUM_REQ-1:0];
  end

  // Upper bits of the full-width helpers are always zero.
  assign unused_ext = ^{rot_ext, nxt0_ext, nxt1_ext};

  // Next grants and pointer; hold suppresses grants and freezes the pointer.
  always_comb begin
    gnt0_d    = '0;
    gnt1_d    = '0;
    gnt_cnt_d = '0;
    ptr_d     = ptr_q;
    sel_ext   = (|nxt1) ? nxt1_ext : nxt0_ext;
    last_idx  = onehot_to_idx(sel_ext);
    if (!hold_i) begin
      gnt0_d    = nxt0;
      gnt1_d    = nxt1;
      // Grants are disjoint one-hots, so popcount is the sum of their non-zero flags.
      gnt_cnt_d = {1'b0, |nxt0} + {1'b0, |nxt1};
      if (|nxt0) begin
        ptr_d = (last_idx == ptr_t'(NUM_REQ - 1)) ? '0 : PTR_W'(last_idx + ptr_t'(1));
      end
    end
  end

  // Grant and pointer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt0_q    <= '0;
      gnt1_q    <= '0;
      gnt_cnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      gnt_cnt_q <= gnt_cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign gnt_cnt_o = gnt_cnt_q;
  assign ptr_o     = ptr_q;

endmodule
